// File: rtl/gray_counter.sv
// Gray-code up-counter with a sticky wrap flag; Output is the Gray encoding of a binary register.
// Define GRAY_BIN_OUT_EN to also expose the internal binary count on port Binary.
module gray_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [WIDTH-1:0] Output,
`ifdef GRAY_BIN_OUT_EN
    output logic [WIDTH-1:0] Binary,
`endif
    output logic             Overflow
);

    if (WIDTH < 2) begin : g_width_check
        $error("gray_counter: WIDTH must be at least 2");
    end

    // Initial values give a defined count before the first Reset.
    logic [WIDTH-1:0] bin_q = '0;
    logic [WIDTH-1:0] bin_d;
    logic             ovf_q = 1'b0;
    logic             ovf_d;

    always_comb begin
        bin_d = bin_q;
        ovf_d = ovf_q;
        if (Reset) begin
            bin_d = '0;
            ovf_d = 1'b0;
        end else if (En) begin
            bin_d = bin_q + WIDTH'(1);
            if (&bin_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        bin_q <= bin_d;
        ovf_q <= ovf_d;
    end

    assign Output   = bin_q ^ (bin_q >> 1);
    assign Overflow = ovf_q;

`ifdef GRAY_BIN_OUT_EN
    assign Binary = bin_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (WIDTH=3); checks Binary when GRAY_BIN_OUT_EN is set.
module tb_gray_counter;

    localparam int unsigned WIDTH = 3;

    logic             Clk;
    logic             Reset;
    logic             En;
    logic [WIDTH-1:0] Output;
    logic             Overflow;
`ifdef GRAY_BIN_OUT_EN
    logic [WIDTH-1:0] Binary;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Hand-written WIDTH=3 Gray sequence indexed by binary count.
    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    gray_counter #(
        .WIDTH(WIDTH)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .Output  (Output),
`ifdef GRAY_BIN_OUT_EN
        .Binary  (Binary),
`endif
        .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic rst, input logic en);
        Reset = rst;
        En    = en;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_powerup;
        #1;
        n_checks++;
        if (Output !== 3'b000 || Overflow !== 1'b0)
            $display("FAIL powerup: got out=%b ovf=%b required out=000 ovf=0", Output, Overflow);
        else n_pass++;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1);
        n_checks++;
        if (Output !== 3'b000 || Overflow !== 1'b0)
            $display("FAIL reset: got out=%b ovf=%b required out=000 ovf=0", Output, Overflow);
        else n_pass++;
`ifdef GRAY_BIN_OUT_EN
        n_checks++;
        if (Binary !== 3'd0) $display("FAIL reset_binary: got %0d required 0", Binary);
        else n_pass++;
`endif
    endtask

    task automatic test_count;
        logic [2:0] exp_seq [7] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (Output !== exp_seq[i] || Overflow !== 1'b0)
                $display("FAIL count[%0d]: got out=%b ovf=%b required out=%b ovf=0",
                         i, Output, Overflow, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        logic [2:0] exp_seq [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (Output !== exp_seq[i] || Overflow !== 1'b1)
                $display("FAIL wrap[%0d]: got out=%b ovf=%b required out=%b ovf=1",
                         i, Output, Overflow, exp_seq[i]);
            else n_pass++;
        end
    endtask

    // Starts at 010 with Overflow set; a second wrap lands on 011 before holding.
    task automatic test_hold;
        logic [2:0] exp_seq [7] = '{3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001, 3'b011};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if (Output !== exp_seq[i] || Overflow !== 1'b1)
                $display("FAIL rewrap[%0d]: got out=%b ovf=%b required out=%b ovf=1",
                         i, Output, Overflow, exp_seq[i]);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            n_checks++;
            if (Output !== 3'b011 || Overflow !== 1'b1)
                $display("FAIL hold[%0d]: got out=%b ovf=%b required out=011 ovf=1",
                         i, Output, Overflow);
            else n_pass++;
        end
        step(1'b0, 1'b1);
        n_checks++;
        if (Output !== 3'b010 || Overflow !== 1'b1)
            $display("FAIL hold_resume: got out=%b ovf=%b required out=010 ovf=1", Output, Overflow);
        else n_pass++;
    endtask

    task automatic test_mid_reset;
        step(1'b0, 1'b1);
        n_checks++;
        if (Output !== 3'b110 || Overflow !== 1'b1)
            $display("FAIL pre_reset: got out=%b ovf=%b required out=110 ovf=1", Output, Overflow);
        else n_pass++;
        step(1'b1, 1'b1);
        n_checks++;
        if (Output !== 3'b000 || Overflow !== 1'b0)
            $display("FAIL mid_reset: got out=%b ovf=%b required out=000 ovf=0", Output, Overflow);
        else n_pass++;
        step(1'b0, 1'b1);
        n_checks++;
        if (Output !== 3'b001 || Overflow !== 1'b0)
            $display("FAIL post_reset: got out=%b ovf=%b required out=001 ovf=0", Output, Overflow);
        else n_pass++;
    endtask

    task automatic test_one_bit;
        logic [2:0] prev;
        step(1'b1, 1'b0);
        prev = Output;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b1);
            n_checks++;
            if ($countones(prev ^ Output) != 1 || Output !== gseq[i % 8])
                $display("FAIL one_bit[%0d]: got prev=%b out=%b required out=%b one-bit change",
                         i, prev, Output, gseq[i % 8]);
            else n_pass++;
            n_checks++;
            if (Overflow !== (i >= 8))
                $display("FAIL one_bit_ovf[%0d]: got %b required %b", i, Overflow, (i >= 8));
            else n_pass++;
`ifdef GRAY_BIN_OUT_EN
            n_checks++;
            if (Binary !== 3'(i % 8) || Output !== (Binary ^ (Binary >> 1)))
                $display("FAIL binary[%0d]: got bin=%0d out=%b required bin=%0d", i, Binary,
                         Output, i % 8);
            else n_pass++;
`endif
            prev = Output;
        end
    endtask

    initial begin
        Reset = 1'b0;
        En    = 1'b0;
        test_powerup();
        test_reset();
        test_count();
        test_wrap();
        test_hold();
        test_mid_reset();
        test_one_bit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
